// File: rtl/score_display.sv
// rtl/score_display.sv - saturating BCD score counter rendered as scaled 5x7 glyphs
// Optional feature macro: SCORE_LZB_EN (leading-zero blanking).
module score_display #(
  parameter int          DIGITS     = 4,
  parameter int          SCORE_X    = 16,
  parameter int          SCORE_Y    = 16,
  parameter int          SCALE_LOG2 = 1,
  parameter logic [23:0] COLOR      = 24'hFFFFFF
) (
  input  logic                pixel_clk,
  input  logic                rst,
  input  logic                fsync,
  input  logic signed [11:0]  hpos,
  input  logic signed [11:0]  vpos,
  input  logic                hit,
  input  logic                clear,
  output logic [7:0]          pixel [0:2],
  output logic                active,
  output logic [4*DIGITS-1:0] score_bcd
);

  localparam int DW = 11 - SCALE_LOG2;
  localparam logic signed [13:0] X0    = 14'(SCORE_X);
  localparam logic signed [13:0] Y0    = 14'(SCORE_Y);
  localparam logic signed [13:0] W_PIX = 14'(DIGITS * 8 * (1 << SCALE_LOG2));
  localparam logic signed [13:0] H_PIX = 14'(8 * (1 << SCALE_LOG2));

  logic                hit_q;
  logic [2:0]          pending_q, pending_d;
  logic [4*DIGITS-1:0] score_q, score_d, score_inc;
  logic                hit_evt, carry, all_nines;

  assign hit_evt = hit & ~hit_q;

  // BCD ripple increment; an all-nines score holds instead of wrapping
  always_comb begin
    score_inc = score_q;
    carry     = 1'b1;
    all_nines = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (score_q[4*i +: 4] != 4'd9) all_nines = 1'b0;
      if (carry) begin
        if (score_q[4*i +: 4] == 4'd9) begin
          score_inc[4*i +: 4] = 4'd0;
        end else begin
          score_inc[4*i +: 4] = score_q[4*i +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
    end
    if (all_nines) score_inc = score_q;
  end

  always_comb begin
    pending_d = pending_q;
    score_d   = score_q;
    if (fsync && (hit_evt || pending_q != 3'd0)) begin
      score_d = score_inc;
      if (!hit_evt) pending_d = pending_q - 3'd1;
    end else if (hit_evt && !fsync && pending_q != 3'd7) begin
      pending_d = pending_q + 3'd1;
    end
  end

  always_ff @(posedge pixel_clk) begin
    if (rst || clear) begin
      hit_q     <= 1'b0;
      pending_q <= 3'd0;
      score_q   <= '0;
    end else begin
      hit_q     <= hit;
      pending_q <= pending_d;
      score_q   <= score_d;
    end
  end

  assign score_bcd = score_q;

  function automatic logic [34:0] glyph(input logic [3:0] n);
    case (n)
      4'd0:    glyph = 35'b01110_10001_10011_10101_11001_10001_01110;
      4'd1:    glyph = 35'b00100_01100_00100_00100_00100_00100_01110;
      4'd2:    glyph = 35'b01110_10001_00001_00010_00100_01000_11111;
      4'd3:    glyph = 35'b11111_00010_00100_00010_00001_10001_01110;
      4'd4:    glyph = 35'b00010_00110_01010_10010_11111_00010_00010;
      4'd5:    glyph = 35'b11111_10000_11110_00001_00001_10001_01110;
      4'd6:    glyph = 35'b00110_01000_10000_11110_10001_10001_01110;
      4'd7:    glyph = 35'b11111_00001_00010_00100_01000_01000_01000;
      4'd8:    glyph = 35'b01110_10001_10001_01110_10001_10001_01110;
      4'd9:    glyph = 35'b01110_10001_10001_01111_00001_00010_01100;
      default: glyph = '0;
    endcase
  endfunction

  // Render from hpos+1 so the registered output lines up with the current pixel
  logic signed [13:0] hl, dx, dy;
  logic               in_region, blank, bit_on, fg;
  logic [DW-1:0]      dig_w;
  logic [2:0]         col, row;
  logic [3:0]         cur_nib;
  logic [34:0]        glyph_bits;
  logic [4:0]         row_bits;

  assign hl        = {{2{hpos[11]}}, hpos} + 14'sd1;
  assign dx        = hl - X0;
  assign dy        = {{2{vpos[11]}}, vpos} - Y0;
  assign in_region = (dx >= 14'sd0) && (dx < W_PIX) && (dy >= 14'sd0) && (dy < H_PIX);
  assign dig_w     = dx[13:3+SCALE_LOG2];
  assign col       = dx[SCALE_LOG2 +: 3];
  assign row       = dy[SCALE_LOG2 +: 3];

`ifdef SCORE_LZB_EN
  logic lead;
  always_comb begin
    cur_nib = 4'd0;
    blank   = 1'b0;
    lead    = 1'b1;
    for (int d = 0; d < DIGITS; d++) begin
      if (score_q[4*(DIGITS-1-d) +: 4] != 4'd0) lead = 1'b0;
      if (dig_w == DW'(d)) begin
        cur_nib = score_q[4*(DIGITS-1-d) +: 4];
        blank   = lead && (d != DIGITS - 1);
      end
    end
  end
`else
  always_comb begin
    cur_nib = 4'd0;
    blank   = 1'b0;
    for (int d = 0; d < DIGITS; d++) begin
      if (dig_w == DW'(d)) cur_nib = score_q[4*(DIGITS-1-d) +: 4];
    end
  end
`endif

  always_comb begin
    glyph_bits = glyph(cur_nib);
    row_bits   = 5'd0;
    bit_on     = 1'b0;
    for (int r = 0; r < 7; r++) begin
      if (row == 3'(r)) row_bits = glyph_bits[5*(6-r) +: 5];
    end
    for (int c = 0; c < 5; c++) begin
      if (col == 3'(c)) bit_on = row_bits[4-c];
    end
    fg = in_region && !blank && bit_on;
  end

  logic       active_q;
  logic [7:0] red_q, grn_q, blu_q;

  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      active_q <= 1'b0;
      red_q    <= 8'd0;
      grn_q    <= 8'd0;
      blu_q    <= 8'd0;
    end else begin
      active_q <= fg;
      red_q    <= fg ? COLOR[23:16] : 8'd0;
      grn_q    <= fg ? COLOR[15:8]  : 8'd0;
      blu_q    <= fg ? COLOR[7:0]   : 8'd0;
    end
  end

  assign active   = active_q;
  assign pixel[0] = blu_q;
  assign pixel[1] = grn_q;
  assign pixel[2] = red_q;

endmodule

// File: tb/tb_score_display.sv
// tb/tb_score_display.sv - directed self-checking bench for score_display
module tb_score_display;

  logic               pixel_clk = 1'b0;
  logic               rst, fsync, hit, clear;
  logic signed [11:0] hpos, vpos;
  logic [7:0]         pixel [0:2];
  logic               active;
  logic [15:0]        score_bcd;
  int                 n_cmp = 0;
  int                 n_err = 0;

  always #5 pixel_clk = ~pixel_clk;

  score_display dut (
    .pixel_clk(pixel_clk), .rst(rst), .fsync(fsync), .hpos(hpos), .vpos(vpos),
    .hit(hit), .clear(clear), .pixel(pixel), .active(active), .score_bcd(score_bcd)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge pixel_clk);
    #1;
  endtask

  task automatic bump();
    hit = 1'b1; fsync = 1'b1; tick();
    hit = 1'b0; fsync = 1'b0; tick();
  endtask

  task automatic frame();
    fsync = 1'b1; tick(); fsync = 1'b0;
  endtask

  // pixels h0..h1 on line v; foreground expected exactly for on0..on1
  task automatic sweep(input string tag, input int v, input int h0, input int h1,
                       input int on0, input int on1);
    logic on;
    vpos = 12'(v);
    for (int h = h0; h <= h1; h++) begin
      hpos = 12'(h - 1);
      tick();
      hpos = 12'(h);
      on = (h >= on0) && (h <= on1);
      check($sformatf("%s act h=%0d", tag, h), active, on);
      check($sformatf("%s rgb h=%0d", tag, h), {pixel[2], pixel[1], pixel[0]},
            on ? 24'hFFFFFF : 24'h000000);
    end
    hpos = -12'sd100;
    vpos = -12'sd100;
  endtask

  initial begin
    rst = 1'b1; fsync = 1'b0; hit = 1'b0; clear = 1'b0;
    hpos = -12'sd100; vpos = -12'sd100;
    tick(); tick();
    rst = 1'b0;
    tick();
    check("rst score", score_bcd, 16'h0000);
    check("rst active", active, 1'b0);
    check("rst red", pixel[2], 8'h00);
    check("rst blue", pixel[0], 8'h00);

    hit = 1'b1; tick(); hit = 1'b0; tick(); tick();
    check("deferred", score_bcd, 16'h0000);
    frame();
    check("one hit", score_bcd, 16'h0001);

    sweep("glyph1", 16, 62, 74, 68, 69);

    hit = 1'b1;
    repeat (50) tick();
    frame();
    hit = 1'b0;
    tick();
    check("held hit", score_bcd, 16'h0002);
    frame();
    check("held no extra", score_bcd, 16'h0002);

    repeat (3) begin
      hit = 1'b1; tick(); hit = 1'b0; tick();
    end
    check("three queued", score_bcd, 16'h0002);
    frame(); check("drain 1", score_bcd, 16'h0003);
    frame(); check("drain 2", score_bcd, 16'h0004);
    frame(); check("drain 3", score_bcd, 16'h0005);
    frame(); check("drained", score_bcd, 16'h0005);

    clear = 1'b1; tick(); clear = 1'b0;
    check("clear", score_bcd, 16'h0000);
    repeat (9) bump();
    check("nine", score_bcd, 16'h0009);
    bump();
    check("carry", score_bcd, 16'h0010);
    repeat (9989) bump();
    check("max", score_bcd, 16'h9999);
    bump();
    check("saturate", score_bcd, 16'h9999);

    clear = 1'b1; tick(); clear = 1'b0;
    repeat (42) bump();
    check("load 42", score_bcd, 16'h0042);
    hit = 1'b1; tick(); hit = 1'b0; tick();
    vpos = 12'sd20; hpos = 12'sd20;
    clear = 1'b1; tick(); clear = 1'b0;
    check("mid clear", score_bcd, 16'h0000);
    frame();
    check("pending cleared", score_bcd, 16'h0000);

    sweep("row0", 16, 14, 26, 18, 23);
    sweep("row7", 30, 16, 24, 1, 0);
    sweep("above", 15, 16, 24, 1, 0);
    sweep("neg h", 16, -3, 1, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
